alu_cmd_seq: RTL and testbench
==============================

Name: alu_cmd_seq

Overview:
- Upstream command sequencer for the registered ALU stage (operand registers A/B, result register F, flag register FR).
- Accepts ALU commands (op, operand A, operand B) through a valid/ready interface and buffers them in a small FIFO.
- Sequences the load-A / load-B / load-F strobes into the ALU stage, captures F and FR, and presents the result on a valid/ready output.
- Counts completed operations.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of two, ≥2.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_op  input  4  ALU opcode.
- cmd_a  input  32  operand A.
- cmd_b  input  32  operand B.
- alu_op  output  4  opcode driven to the ALU stage.
- data_a  output  32  operand A driven to the ALU stage.
- data_b  output  32  operand B driven to the ALU stage.
- load_a  output  1  one-cycle enable; the ALU stage captures data_a at this edge.
- load_b  output  1  one-cycle enable; the ALU stage captures data_b.
- load_f  output  1  one-cycle enable; the ALU stage captures F and FR.
- f_in  input  32  registered F from the ALU stage.
- fr_in  input  4  registered FR {ZF,CF,OF,SF} from the ALU stage.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_f  output  32  captured result.
- res_fr  output  4  captured flags.
- op_count  output  CNT_W  completed results, wrapping.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - FIFO empties; state goes to IDLE.
  - alu_op, data_a, data_b, res_f, res_fr, op_count are 0.
  - load_a, load_b, load_f, res_valid, busy are 0.
  - cmd_ready goes to 1 one cycle after rst deasserts, and during reset is 0.
- FIFO:
  - cmd_ready = !full.
  - A push occurs when cmd_valid & cmd_ready. There is no bypass: a push into an empty FIFO is visible to the FSM the next cycle.
  - The FSM pops only in IDLE when the FIFO is not empty.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - Pointers wrap modulo DEPTH.
  - A push while full is impossible because cmd_ready=0; cmd_valid is ignored.
- FSM states and transitions:
  - IDLE: if FIFO not empty, pop; latch op/a/b into the current-command registers; next state LOAD_A.
  - LOAD_A: load_a=1; next LOAD_B.
  - LOAD_B: load_b=1; next EXEC.
  - EXEC: load_f=1 (the ALU computes combinationally from the registered A/B); next CAPT.
  - CAPT: res_f<=f_in, res_fr<=fr_in; next RESULT.
  - RESULT: res_valid=1. Stay until res_ready=1. On the handshake edge, op_count increments (wrapping from all-ones to 0) and the next state is IDLE.
- Strobe and output rules:
  - Strobes are mutually exclusive, at most one cycle each per command.
  - alu_op, data_a, data_b are driven continuously from the current-command registers and hold their values through RESULT until the next pop.
  - res_f and res_fr hold until the next CAPT.
- Latency:
  - Command accepted at edge N (FIFO empty, FSM in IDLE) → pop at N+1 → load_a high in cycle N+2 → res_valid high from cycle N+6.
  - Minimum spacing between results is 6 cycles with res_ready held high.
- Backpressure: while in RESULT with res_ready=0, the FSM stalls and the FIFO keeps accepting until full.
- Reset mid-operation: any in-flight command and all queued commands are discarded. No strobe may be emitted in the cycle rst is high.
- No arithmetic is performed here; f_in and fr_in pass through unmodified.

Test Plan:
- Bench model for all scenarios: the ALU stage is modelled as add, so F=A+B registered on load_f and FR={ZF,CF,OF,SF}.
- Single op: op=0, a=32'h0000_0005, b=32'h0000_0003 pushed at edge N → strobes in cycles N+2/N+3/N+4, res_valid at N+6 with res_f=8 and res_fr=4'b0000; op_count=1 after handshake.
- Flags: a=32'hFFFF_FFFF, b=1 → res_f=0, res_fr=4'b1100 (ZF, CF set).
- FIFO full/backpressure: hold res_ready=0 and push 5 commands with DEPTH=4 → the first pops and its result stalls. Four more are accepted. cmd_ready=0 with 4 queued until a handshake frees one entry. Release res_ready → results emerge in order, 6 cycles apart.
- Simultaneous push/pop: push exactly on the IDLE pop cycle with 1 entry queued → occupancy stays 1 and no command is lost or duplicated.
- Reset mid-op: assert rst during EXEC with 2 commands queued → load_f drops immediately; after release, busy=0, res_valid=0, op_count=0, and no stale result is produced.
- Counter wrap: CNT_W=4, 17 completed ops → op_count reads 15 after op 15, 0 after op 16, and 1 after op 17.

Source files
------------

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: buffers ALU commands in a FIFO and sequences load strobes, result capture and handshake.
module alu_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  output logic [3:0]       alu_op,
  output logic [31:0]      data_a,
  output logic [31:0]      data_b,
  output logic             load_a,
  output logic             load_b,
  output logic             load_f,
  input  logic [31:0]      f_in,
  input  logic [3:0]       fr_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_f,
  output logic [3:0]       res_fr,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, CAPT, RESULT} state_t;
  state_t r_state, w_next;
  logic [67:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic r_init;
  logic [3:0] r_op;
  logic [31:0] r_a, r_b, r_f;
  logic [3:0] r_fr;
  logic [CNT_W-1:0] r_cnt;
  logic w_empty, w_full, w_push, w_pop;
  assign w_empty = r_wp == r_rp;
  assign w_full = (r_wp - r_rp) == (AW+1)'(DEPTH);
  // r_init keeps cmd_ready low during reset and for the edge that releases it
  assign cmd_ready = r_init & ~w_full;
  assign w_push = cmd_valid & cmd_ready;
  assign w_pop = (r_state == IDLE) & ~w_empty;
  assign alu_op = r_op;
  assign data_a = r_a;
  assign data_b = r_b;
  assign load_a = r_state == LOAD_A;
  assign load_b = r_state == LOAD_B;
  assign load_f = r_state == EXEC;
  assign res_valid = r_state == RESULT;
  assign busy = r_state != IDLE;
  assign res_f = r_f;
  assign res_fr = r_fr;
  assign op_count = r_cnt;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_wp <= '0;
      r_rp <= '0;
      r_init <= 1'b0;
      r_op <= '0;
      r_a <= '0;
      r_b <= '0;
      r_f <= '0;
      r_fr <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_init <= 1'b1;
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_pop) begin
        r_rp <= r_rp + (AW+1)'(1);
        {r_op, r_a, r_b} <= r_mem[r_rp[AW-1:0]];
      end
      if (r_state == CAPT) begin
        r_f <= f_in;
        r_fr <= fr_in;
      end
      if (r_state == RESULT && res_ready) r_cnt <= r_cnt + CNT_W'(1);
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_empty ? IDLE : LOAD_A;
      LOAD_A:  w_next = LOAD_B;
      LOAD_B:  w_next = EXEC;
      EXEC:    w_next = CAPT;
      CAPT:    w_next = RESULT;
      RESULT:  w_next = res_ready ? IDLE : RESULT;
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: add-ALU environment, scoreboard model and directed plus random stimulus for alu_cmd_seq.
module tb_alu_cmd_seq;
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [3:0] cmd_op = 0;
  logic [31:0] cmd_a = 0, cmd_b = 0;
  logic [3:0] alu_op;
  logic [31:0] data_a, data_b;
  logic load_a, load_b, load_f;
  logic [31:0] f_in = 0;
  logic [3:0] fr_in = 0;
  logic res_valid, res_ready = 0;
  logic [31:0] res_f;
  logic [3:0] res_fr;
  logic [3:0] op_count;
  logic busy;
  int checks = 0, errors = 0, cyc = 0, mcount = 0;
  cmd_t sb[$];
  cmd_t cur;
  bit cur_v = 0, res_pend = 0;
  int hs_cyc[$];
  logic [31:0] alu_a = 0, alu_b = 0;

  alu_cmd_seq #(.DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_op(alu_op),
    .data_a(data_a), .data_b(data_b), .load_a(load_a), .load_b(load_b),
    .load_f(load_f), .f_in(f_in), .fr_in(fr_in), .res_valid(res_valid),
    .res_ready(res_ready), .res_f(res_f), .res_fr(res_fr),
    .op_count(op_count), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [35:0] add_model(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {s[31:0], s[31:0] == 0, s[32], (a[31] == b[31]) && (s[31] != a[31]), s[31]};
  endfunction

  // ALU stage environment: registered A/B, F/FR registered on load_f
  always @(posedge clk) begin
    if (load_a) alu_a <= data_a;
    if (load_b) alu_b <= data_b;
    if (load_f) {f_in, fr_in} <= add_model(alu_a, alu_b);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("strobes_in_reset", {61'd0, load_a, load_b, load_f}, 0);
      sb.delete();
      cur_v = 0;
      res_pend = 0;
      mcount = 0;
    end else begin
      logic [35:0] e;
      chk("op_count", op_count, 64'(mcount % 16));
      chk("strobe_onehot", $countones({load_a, load_b, load_f}) <= 1, 1);
      if (load_a) begin
        if (sb.size() == 0 || res_pend) chk("load_a_unexpected", 1, 0);
        else begin
          cur = sb.pop_front();
          cur_v = 1;
          res_pend = 1;
        end
      end
      if ((load_b || load_f) && !res_pend) chk("strobe_without_cmd", 1, 0);
      if (cur_v) begin
        chk("alu_op", alu_op, cur.op);
        chk("data_a", data_a, cur.a);
        chk("data_b", data_b, cur.b);
      end
      if (res_valid) begin
        if (!res_pend) chk("res_valid_unexpected", 1, 0);
        else begin
          e = add_model(cur.a, cur.b);
          chk("res_f", res_f, e[35:4]);
          chk("res_fr", res_fr, e[3:0]);
          if (res_ready) begin
            mcount++;
            res_pend = 0;
            hs_cyc.push_back(cyc);
          end
        end
      end
      if (cmd_valid && cmd_ready) sb.push_back({cmd_op, cmd_a, cmd_b});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    cmd_valid = 1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("push_timeout", 0, 1);
    step();
    cmd_valid = 0;
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    while (mcount < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (mcount < target) chk("handshake_timeout", mcount, target);
    step();
  endtask

  initial begin
    int la, lb, lf, rv, n;
    #2;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_data_a", data_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_res_f", res_f, 0);
    repeat (3) step();
    rst = 0;
    chk("cmd_ready_after_release", cmd_ready, 0);
    step();
    chk("cmd_ready_one_cycle_later", cmd_ready, 1);
    // single op latency
    res_ready = 1;
    cmd_valid = 1;
    cmd_op = 0;
    cmd_a = 32'h5;
    cmd_b = 32'h3;
    step();
    cmd_valid = 0;
    la = 0; lb = 0; lf = 0; rv = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (load_a && la == 0) la = k;
      if (load_b && lb == 0) lb = k;
      if (load_f && lf == 0) lf = k;
      if (res_valid && rv == 0) begin
        rv = k;
        chk("single_res_f", res_f, 8);
        chk("single_res_fr", res_fr, 0);
      end
    end
    chk("lat_load_a", la, 2);
    chk("lat_load_b", lb, 3);
    chk("lat_load_f", lf, 4);
    chk("lat_res_valid", rv, 6);
    chk("single_op_count", op_count, 1);
    step();
    // flags
    push(0, 32'hFFFF_FFFF, 32'h1);
    n = 0;
    while (!res_valid && n < 20) begin step(); n++; end
    chk("flags_res_f", res_f, 0);
    chk("flags_res_fr", res_fr, 4'b1100);
    wait_cnt(2);
    // fifo full / backpressure
    res_ready = 0;
    for (int i = 0; i < 5; i++) push(4'(i), 32'(i * 100), 32'(i + 7));
    repeat (6) step();
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_res_valid", res_valid, 1);
    chk("full_busy", busy, 1);
    res_ready = 1;
    @(negedge clk);
    chk("full_before_hs", cmd_ready, 0);
    @(negedge clk);
    chk("full_after_hs", cmd_ready, 0);
    @(negedge clk);
    chk("full_after_pop", cmd_ready, 1);
    step();
    wait_cnt(7);
    n = hs_cyc.size();
    for (int i = n - 4; i < n; i++) chk("result_spacing", hs_cyc[i] - hs_cyc[i-1], 6);
    // simultaneous push and pop
    res_ready = 0;
    push(1, 32'h1111, 32'h2222);
    n = 0;
    while (!res_valid && n < 20) begin step(); n++; end
    push(2, 32'h3333, 32'h4444);
    res_ready = 1;
    step();
    chk("pushpop_ready", cmd_ready, 1);
    cmd_valid = 1;
    cmd_op = 3;
    cmd_a = 32'h8000_0000;
    cmd_b = 32'h8000_0000;
    step();
    cmd_valid = 0;
    chk("pushpop_load_a", load_a, 1);
    chk("pushpop_ready_after", cmd_ready, 1);
    wait_cnt(10);
    // reset mid-operation
    push(4, 32'hA, 32'hB);
    push(5, 32'hC, 32'hD);
    push(6, 32'hE, 32'hF);
    n = 0;
    while (!load_f && n < 20) begin step(); n++; end
    chk("reached_exec", load_f, 1);
    rst = 1;
    #1;
    chk("midrst_load_f", load_f, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    step();
    step();
    rst = 0;
    chk("midrst_release_ready", cmd_ready, 0);
    step();
    chk("midrst_ready_back", cmd_ready, 1);
    repeat (10) step();
    chk("midrst_idle", busy, 0);
    chk("midrst_no_result", res_valid, 0);
    chk("midrst_count", op_count, 0);
    // counter wrap
    for (int i = 1; i <= 17; i++) begin
      push(4'(i), 32'(i), 32'(i * 3));
      wait_cnt(i);
      if (i == 15) chk("wrap_15", op_count, 15);
      if (i == 16) chk("wrap_16", op_count, 0);
      if (i == 17) chk("wrap_17", op_count, 1);
    end
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 4'($urandom);
      cmd_a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      cmd_b = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      res_ready = $urandom_range(0, 3) != 0;
      step();
    end
    cmd_valid = 0;
    res_ready = 1;
    repeat (80) step();
    chk("drain_queue_empty", sb.size(), 0);
    chk("drain_no_pending", res_pend, 0);
    chk("drain_idle", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
